// File: rtl/key_input_hub.sv
// key_input_hub: synchronises and debounces active-low push-buttons, adds
// optional auto-repeat, and routes one-cycle press pulses to the latched target.
module key_input_hub #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned N_TARGETS       = 5,
  parameter int unsigned SEL_W           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_KEYS-1:0]             i_key_n,
  input  logic [SEL_W-1:0]              i_sel,
  input  logic                          i_repeat_en,
  output logic [N_KEYS-1:0]             o_level,
  output logic [N_TARGETS*N_KEYS-1:0]   o_pulse,
  output logic [SEL_W-1:0]              o_sel,
  output logic                          o_sel_err
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    REL    = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [N_KEYS-1:0]           sync1_q, sync1_d;
  logic [N_KEYS-1:0]           sync2_q, sync2_d;
  logic [N_KEYS-1:0]           pressed;
  logic [N_KEYS-1:0]           level_q, level_d;
  logic [CNT_W-1:0]            db_cnt_q [N_KEYS];
  logic [CNT_W-1:0]            db_cnt_d [N_KEYS];
  state_e                      st_q [N_KEYS];
  state_e                      st_d [N_KEYS];
  logic [CNT_W-1:0]            rp_cnt_q [N_KEYS];
  logic [CNT_W-1:0]            rp_cnt_d [N_KEYS];
  logic [N_KEYS-1:0]           key_pulse;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic                        sel_err_q, sel_err_d;
  logic [N_TARGETS*N_KEYS-1:0] pulse_q, pulse_d;

  // Two-flop synchroniser shift; pressed is the active-high synchronised key.
  always_comb begin
    sync1_d = i_key_n;
    sync2_d = sync1_q;
    pressed = ~sync2_q;
  end

  // Synchroniser flops reset to the released (high) level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce: count consecutive cycles of disagreement, toggle level on the last one.
  always_comb begin
    level_d = level_q;
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      db_cnt_d[k] = db_cnt_q[k];
      if (pressed[k] == level_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] >= DB_LAST) begin
        level_d[k]  = ~level_q[k];
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] != '1) begin
        db_cnt_d[k] = db_cnt_q[k] + CNT_ONE;
      end
    end
  end

  // Per-key repeat FSM; decisions use the next level so the press pulse
  // registers on the same edge that o_level rises.
  always_comb begin
    key_pulse = '0;
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      st_d[k]     = st_q[k];
      rp_cnt_d[k] = rp_cnt_q[k];
      if (!level_d[k]) begin
        st_d[k]     = REL;
        rp_cnt_d[k] = '0;
      end else begin
        case (st_q[k])
          REL: begin
            st_d[k]      = DELAY;
            rp_cnt_d[k]  = '0;
            key_pulse[k] = 1'b1;
          end
          DELAY: begin
            if (!i_repeat_en) begin
              rp_cnt_d[k] = '0;
            end else if (rp_cnt_q[k] >= DLY_LAST) begin
              st_d[k]      = REPEAT;
              rp_cnt_d[k]  = '0;
              key_pulse[k] = 1'b1;
            end else if (rp_cnt_q[k] != '1) begin
              rp_cnt_d[k] = rp_cnt_q[k] + CNT_ONE;
            end
          end
          REPEAT: begin
            if (!i_repeat_en) begin
              st_d[k]     = DELAY;
              rp_cnt_d[k] = '0;
            end else if (rp_cnt_q[k] >= PER_LAST) begin
              rp_cnt_d[k]  = '0;
              key_pulse[k] = 1'b1;
            end else if (rp_cnt_q[k] != '1) begin
              rp_cnt_d[k] = rp_cnt_q[k] + CNT_ONE;
            end
          end
          default: begin
            st_d[k]     = REL;
            rp_cnt_d[k] = '0;
          end
        endcase
      end
    end
  end

  // Target latch only while every key is released; pulses follow the newly latched target.
  always_comb begin
    sel_d     = (level_q == '0) ? i_sel : sel_q;
    sel_err_d = (32'(sel_d) >= N_TARGETS);
    pulse_d   = '0;
    for (int unsigned t = 0; t < N_TARGETS; t++) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        pulse_d[t*N_KEYS+k] = key_pulse[k] && !sel_err_d && (sel_d == SEL_W'(t));
      end
    end
  end

  // State registers for debounce, repeat FSMs, target latch and pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q   <= '0;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
      pulse_q   <= '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k] <= '0;
        rp_cnt_q[k] <= '0;
        st_q[k]     <= REL;
      end
    end else begin
      level_q   <= level_d;
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
      pulse_q   <= pulse_d;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
        rp_cnt_q[k] <= rp_cnt_d[k];
        st_q[k]     <= st_d[k];
      end
    end
  end

  assign o_level   = level_q;
  assign o_pulse   = pulse_q;
  assign o_sel     = sel_q;
  assign o_sel_err = sel_err_q;

endmodule

// File: tb/tb_key_input_hub.sv
// Directed bench for key_input_hub with short debounce/repeat timings.
module tb_key_input_hub;

  localparam int unsigned NK = 4;
  localparam int unsigned NT = 5;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic [SW-1:0] sel;
  logic          rep_en;
  logic [NK-1:0] level;
  logic [NT*NK-1:0] pulse;
  logic [SW-1:0] osel;
  logic          sel_err;

  int pass_cnt;
  int total_cnt;

  key_input_hub #(
    .N_KEYS(NK), .N_TARGETS(NT), .SEL_W(SW),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_n), .i_sel(sel),
    .i_repeat_en(rep_en), .o_level(level), .o_pulse(pulse),
    .o_sel(osel), .o_sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  key_n;
    logic [2:0]  sel;
    logic        rep;
    int          cyc;   // 0 = settle 1 time unit without a clock edge
    logic [3:0]  lvl;
    logic [19:0] pls;
    logic [2:0]  osel;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] k, input logic [2:0] s, input logic re,
                     input int c, input logic [3:0] l, input logic [19:0] p,
                     input logic [2:0] os, input logic e);
    vec_t v;
    v.rst_n = r; v.key_n = k; v.sel = s; v.rep = re; v.cyc = c;
    v.lvl = l; v.pls = p; v.osel = os; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  int first;
  int extra;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; key_n = 4'hF; sel = '0; rep_en = 1'b0;

    // Reset and test 1: clean press of key 0, repeat off
    add(0, 4'hF, 0, 0, 1, 4'h0, 20'h0, 0, 0);
    add(1, 4'hF, 0, 0, 3, 4'h0, 20'h0, 0, 0);
    add(1, 4'hE, 0, 0, 5, 4'h0, 20'h0, 0, 0);
    add(1, 4'hE, 0, 0, 1, 4'h1, 20'h00001, 0, 0);
    add(1, 4'hE, 0, 0, 1, 4'h1, 20'h0, 0, 0);
    add(1, 4'hE, 0, 0, 20, 4'h1, 20'h0, 0, 0);
    add(1, 4'hF, 0, 0, 5, 4'h1, 20'h0, 0, 0);
    add(1, 4'hF, 0, 0, 1, 4'h0, 20'h0, 0, 0);
    // Test 2: 3-cycle glitch on key 2
    add(1, 4'hB, 0, 0, 3, 4'h0, 20'h0, 0, 0);
    add(1, 4'hF, 0, 0, 10, 4'h0, 20'h0, 0, 0);
    // Test 3: hold key 1 with repeat; release lands on a would-be repeat slot
    add(1, 4'hD, 0, 1, 5, 4'h0, 20'h0, 0, 0);
    add(1, 4'hD, 0, 1, 1, 4'h2, 20'h00002, 0, 0);
    add(1, 4'hD, 0, 1, 9, 4'h2, 20'h0, 0, 0);
    add(1, 4'hD, 0, 1, 1, 4'h2, 20'h00002, 0, 0);
    add(1, 4'hD, 0, 1, 1, 4'h2, 20'h0, 0, 0);
    add(1, 4'hD, 0, 1, 1, 4'h2, 20'h0, 0, 0);
    add(1, 4'hD, 0, 1, 1, 4'h2, 20'h00002, 0, 0);
    add(1, 4'hD, 0, 1, 2, 4'h2, 20'h0, 0, 0);
    add(1, 4'hD, 0, 1, 1, 4'h2, 20'h00002, 0, 0);
    add(1, 4'hF, 0, 1, 6, 4'h0, 20'h0, 0, 0);
    add(1, 4'hF, 0, 1, 5, 4'h0, 20'h0, 0, 0);
    // Test 4: target 3, key 3, select change mid-hold
    add(1, 4'hF, 3, 0, 1, 4'h0, 20'h0, 3, 0);
    add(1, 4'h7, 3, 0, 5, 4'h0, 20'h0, 3, 0);
    add(1, 4'h7, 3, 0, 1, 4'h8, 20'h08000, 3, 0);
    add(1, 4'h7, 1, 0, 3, 4'h8, 20'h0, 3, 0);
    add(1, 4'hF, 1, 0, 5, 4'h8, 20'h0, 3, 0);
    add(1, 4'hF, 1, 0, 1, 4'h0, 20'h0, 3, 0);
    add(1, 4'hF, 1, 0, 1, 4'h0, 20'h0, 1, 0);
    // Test 5: out-of-range selects block pulses; top valid target still routes
    add(1, 4'hF, 6, 0, 1, 4'h0, 20'h0, 6, 1);
    add(1, 4'hE, 6, 0, 6, 4'h1, 20'h0, 6, 1);
    add(1, 4'hF, 6, 0, 6, 4'h0, 20'h0, 6, 1);
    add(1, 4'hF, 4, 0, 1, 4'h0, 20'h0, 4, 0);
    add(1, 4'hB, 4, 0, 6, 4'h4, 20'h40000, 4, 0);
    add(1, 4'hF, 4, 0, 6, 4'h0, 20'h0, 4, 0);
    add(1, 4'hF, 5, 0, 1, 4'h0, 20'h0, 5, 1);
    // Test 6: simultaneous keys 0 and 3, async reset mid-hold, hold through release
    add(1, 4'hF, 2, 0, 1, 4'h0, 20'h0, 2, 0);
    add(1, 4'h6, 2, 0, 6, 4'h9, 20'h00900, 2, 0);
    add(1, 4'h6, 2, 0, 2, 4'h9, 20'h0, 2, 0);
    add(0, 4'h6, 2, 0, 0, 4'h0, 20'h0, 0, 0);
    add(0, 4'h6, 2, 0, 2, 4'h0, 20'h0, 0, 0);
    add(1, 4'h6, 2, 0, 5, 4'h0, 20'h0, 2, 0);
    add(1, 4'h6, 2, 0, 1, 4'h9, 20'h00900, 2, 0);

    foreach (vecs[i]) begin
      rst_n  = vecs[i].rst_n;
      key_n  = vecs[i].key_n;
      sel    = vecs[i].sel;
      rep_en = vecs[i].rep;
      if (vecs[i].cyc == 0) #1;
      else repeat (vecs[i].cyc) tick();
      check($sformatf("v%0d level", i), 32'(level),   32'(vecs[i].lvl));
      check($sformatf("v%0d pulse", i), 32'(pulse),   32'(vecs[i].pls));
      check($sformatf("v%0d sel", i),   32'(osel),    32'(vecs[i].osel));
      check($sformatf("v%0d err", i),   32'(sel_err), 32'(vecs[i].err));
    end

    // Release everything before the repeat-enable sequence
    key_n = 4'hF; rep_en = 1'b0; sel = 3'd0;
    repeat (8) tick();
    check("idle level", 32'(level), 32'h0);

    // Repeat-enable drop in REPEAT returns to the start of the delay count
    key_n = 4'hD; rep_en = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (first == 0 && pulse[1]) first = i;
    end
    // first press pulse 6 edges after the raw edge; loop ran 14 more cycles
    check("press latency", 32'(first), 32'd6);
    // P+14 now: repeats at P+10, P+13; next at P+16
    tick();
    check("no pulse P+15", 32'(pulse), 32'h0);
    tick();
    check("repeat P+16", 32'(pulse), 32'h00002);
    rep_en = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pulse != '0) extra++;
    end
    check("no pulse while disabled", 32'(extra), 32'd0);
    rep_en = 1'b1;
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (first == 0 && pulse[1]) first = i;
    end
    check("restart delay", 32'(first), 32'd10);
    key_n = 4'hF;
    repeat (8) tick();
    check("final level", 32'(level), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
